// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment display path: glyph table ({g,f,e,d,c,b,a}, 1 = lit)
// and the capture FSM state type.
`timescale 1ns/1ps
package seven_seg_pkg;

  localparam logic [6:0] SEG_GLYPH_0 = 7'h3F;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h06;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h5B;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h4F;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h66;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h6D;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h7D;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h07;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h7F;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h6F;
  localparam logic [6:0] SEG_GLYPH_A = 7'h77;
  localparam logic [6:0] SEG_GLYPH_B = 7'h7C;
  localparam logic [6:0] SEG_GLYPH_C = 7'h39;
  localparam logic [6:0] SEG_GLYPH_D = 7'h5E;
  localparam logic [6:0] SEG_GLYPH_E = 7'h79;
  localparam logic [6:0] SEG_GLYPH_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } cap_state_t;

endpackage

// File: rtl/seven_seg_glyph_lookup.sv
// Combinational reverse glyph lookup: segment pattern -> hex nibble, with a flag for
// patterns that are not one of the 16 legal glyphs.
`timescale 1ns/1ps
module seven_seg_glyph_lookup
  import seven_seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       illegal,
  output logic [3:0] nibble
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    illegal = 1'b0;
    nibble  = 4'h0;
    case (pattern)
      SEG_GLYPH_0: nibble = 4'h0;
      SEG_GLYPH_1: nibble = 4'h1;
      SEG_GLYPH_2: nibble = 4'h2;
      SEG_GLYPH_3: nibble = 4'h3;
      SEG_GLYPH_4: nibble = 4'h4;
      SEG_GLYPH_5: nibble = 4'h5;
      SEG_GLYPH_6: nibble = 4'h6;
      SEG_GLYPH_7: nibble = 4'h7;
      SEG_GLYPH_8: nibble = 4'h8;
      SEG_GLYPH_9: nibble = 4'h9;
      SEG_GLYPH_A: nibble = 4'hA;
      SEG_GLYPH_B: nibble = 4'hB;
      SEG_GLYPH_C: nibble = 4'hC;
      SEG_GLYPH_D: nibble = 4'hD;
      SEG_GLYPH_E: nibble = 4'hE;
      SEG_GLYPH_F: nibble = 4'hF;
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of a multiplexed 7-segment bus: waits for each digit to dwell stably,
// decodes its glyph and publishes one word per complete scan of all digits.
`timescale 1ns/1ps
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 8,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] word_out,
  output logic                  word_valid,
  output logic [N_DIGITS-1:0]   digit_err,
  output logic                  err_any
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]            seg_meta, seg_sync, prev_seg;
  logic [N_DIGITS-1:0]   an_meta, an_sync, an_norm, prev_an;
  logic                  changed, one_hot, capture;
  cap_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  illegal;
  logic [3:0]            nibble;
  logic [N_DIGITS-1:0]   seen_q, ferr_q, seen_base, ferr_base;
  logic                  frame_done;
  logic [4*N_DIGITS-1:0] slots_q;

  assign an_norm = AN_ACTIVE_LOW ? ~an_sync : an_sync;
  assign changed = (seg_sync != prev_seg) || (an_norm != prev_an);
  assign one_hot = (an_norm != '0) && ((an_norm & (an_norm - N_DIGITS'(1))) == '0);

  seven_seg_glyph_lookup u_lookup (
    .pattern (seg_sync),
    .illegal (illegal),
    .nibble  (nibble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_meta <= '0;
      seg_sync <= '0;
      an_meta  <= '0;
      an_sync  <= '0;
      prev_seg <= '0;
      prev_an  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so each flop samples the pre-edge value of its source.
      seg_meta <= seg_in;
      seg_sync <= seg_meta;
      an_meta  <= an_in;
      an_sync  <= an_meta;
      prev_seg <= seg_sync;
      prev_an  <= an_norm;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // Any change restarts the dwell; only a one-hot digit select can lead to a capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (changed) begin
      cnt_d   = '0;
      state_d = one_hot ? SETTLE : IDLE;
    end else begin
      case (state_q)
        SETTLE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_LAST) begin
            capture = 1'b1;
            state_d = CAPTURED;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: slot storage has no reset; it is only published after every slot has been rewritten.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_DIGITS; k++) begin
      if (capture && an_norm[k]) slots_q[4*k +: 4] <= nibble;
    end
  end

  // A full seen mask is published one cycle after the capture that filled it.
  assign frame_done = &seen_q;
  assign seen_base  = frame_done ? '0 : seen_q;
  assign ferr_base  = frame_done ? '0 : ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q     <= '0;
      ferr_q     <= '0;
      word_out   <= '0;
      digit_err  <= '0;
      err_any    <= 1'b0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        seen_q <= '0;
        ferr_q <= '0;
      end else begin
        if (frame_done) begin
          word_out   <= slots_q;
          digit_err  <= ferr_q;
          err_any    <= |ferr_q;
          word_valid <= 1'b1;
        end
        seen_q <= capture ? (seen_base | an_norm) : seen_base;
        ferr_q <= capture ? ((ferr_base & ~an_norm) | (illegal ? an_norm : '0)) : ferr_base;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scans plus random traffic, checked every
// cycle against a run-length model of the sampled bus.
`timescale 1ns/1ps
module tb_seven_seg_capture;

  localparam int N = 4;
  localparam int S = 8;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           clear = 1'b0;
  logic [6:0]     seg_in = 7'h00;
  logic [N-1:0]   an_in  = '1;
  logic [4*N-1:0] word_out;
  logic           word_valid;
  logic [N-1:0]   digit_err;
  logic           err_any;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_capture #(.N_DIGITS(N), .STABLE_CYCLES(S), .AN_ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .an_in      (an_in),
    .clear      (clear),
    .word_out   (word_out),
    .word_valid (word_valid),
    .digit_err  (digit_err),
    .err_any    (err_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0]     d1_seg = '0, d2_seg = '0, prev_seg = '0;
  logic [N-1:0]   d1_an = '1, d2_an = '1, prev_an = '0;
  int             run = 0;
  logic [N-1:0]   m_seen = '0, m_ferr = '0;
  logic [4*N-1:0] m_slots = '0;
  logic [4*N-1:0] exp_word = '0;
  logic [N-1:0]   exp_err = '0;
  logic           exp_any = 1'b0, exp_valid = 1'b0;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic model_reset();
    d1_seg = '0; d2_seg = '0; prev_seg = '0;
    d1_an = '1; d2_an = '1; prev_an = '0;
    run = 0; m_seen = '0; m_ferr = '0; m_slots = '0;
    exp_word = '0; exp_err = '0; exp_any = 1'b0; exp_valid = 1'b0;
  endtask

  // The sample judged at an edge is the bus value seen two edges earlier.
  task automatic model_step();
    logic [6:0]   x_seg;
    logic [N-1:0] x_an;
    logic         chg;
    logic [4:0]   dec;
    x_seg = d2_seg; x_an = d2_an;
    d2_seg = d1_seg; d2_an = d1_an;
    d1_seg = seg_in; d1_an = ~an_in;
    chg = (x_seg != prev_seg) || (x_an != prev_an);
    prev_seg = x_seg; prev_an = x_an;
    exp_valid = 1'b0;
    if (clear) begin
      run = 0; m_seen = '0; m_ferr = '0;
    end else begin
      if (&m_seen) begin
        exp_word = m_slots; exp_err = m_ferr; exp_any = |m_ferr; exp_valid = 1'b1;
        m_seen = '0; m_ferr = '0;
      end
      if (chg) run = 1;
      else if (run != 0) run++;
      if (run == S && $countones(x_an) == 1) begin
        dec = ref_decode(x_seg);
        for (int k = 0; k < N; k++) begin
          if (x_an[k]) begin
            m_slots[4*k +: 4] = dec[3:0];
            m_seen[k] = 1'b1;
            m_ferr[k] = dec[4];
          end
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cycle", {10'd0, word_out, word_valid, digit_err, err_any},
                     {10'd0, exp_word, exp_valid, exp_err, exp_any});
      if (word_valid) vcount++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [N-1:0] an, input logic [6:0] seg, input int cyc);
    @(negedge clk);
    an_in = an; seg_in = seg;
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic show(input int d, input logic [6:0] seg, input int cyc);
    drive(~(N'(1) << d), seg, cyc);
  endtask

  task automatic idle_gap();
    drive('1, 7'h00, 12);
    #1;
  endtask

  int base, n;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_word", word_out, 0);
    check("reset_valid", word_valid, 0);
    check("reset_err", {digit_err, err_any}, 0);
    rst_n = 1'b1;
    idle_gap();

    // Basic scan 3..0
    base = vcount;
    show(3, 7'h4F, 20); show(2, 7'h5B, 20); show(1, 7'h06, 20); show(0, 7'h3F, 20);
    idle_gap();
    check("scan_count", vcount - base, 1);
    check("scan_word", word_out, 16'h3210);
    check("scan_err", digit_err, 0);
    check("scan_any", err_any, 0);

    // Short dwell then change: only the new pattern is captured, with fixed latency
    show(0, 7'h6D, 20); show(1, 7'h7D, 20); show(2, 7'h07, 20);
    show(3, 7'h7F, S - 1);
    @(negedge clk);
    seg_in = 7'h6F;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (word_valid) break;
    end
    check("latency_edges", n, 2 + S + 1);
    check("latency_word", word_out, 16'h9765);
    idle_gap();

    // Illegal glyph on digit 2
    base = vcount;
    show(3, 7'h71, 20); show(2, 7'h49, 20); show(1, 7'h79, 20); show(0, 7'h5E, 20);
    idle_gap();
    check("illegal_count", vcount - base, 1);
    check("illegal_word", word_out, 16'hF0ED);
    check("illegal_err", digit_err, 4'b0100);
    check("illegal_any", err_any, 1);

    // Multi-hot and all-off selects never capture and leave seen alone
    base = vcount;
    show(0, 7'h77, 20); show(1, 7'h7C, 20); show(2, 7'h39, 20);
    drive(4'b0011, 7'h06, 50);
    drive(4'b1111, 7'h06, 50);
    #1;
    check("multihot_count", vcount - base, 0);
    show(3, 7'h5E, 20);
    idle_gap();
    check("multihot_done", vcount - base, 1);
    check("multihot_word", word_out, 16'hDCBA);

    // clear discards a partial frame
    base = vcount;
    show(0, 7'h3F, 20); show(1, 7'h06, 20); show(2, 7'h5B, 20);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    show(3, 7'h4F, 20);
    idle_gap();
    check("clear_count", vcount - base, 0);
    check("clear_hold", word_out, 16'hDCBA);
    show(3, 7'h79, 20); show(2, 7'h71, 20); show(1, 7'h6D, 20); show(0, 7'h7D, 20);
    idle_gap();
    check("clear_rescan", vcount - base, 1);
    check("clear_word", word_out, 16'hEF56);

    // clear on the capture edge, then on the completion edge
    for (int off = S + 1; off <= S + 2; off++) begin
      base = vcount;
      show(0, 7'h66, 20); show(1, 7'h66, 20); show(2, 7'h66, 20);
      @(negedge clk);
      an_in = ~(N'(1) << 3); seg_in = 7'h66;
      repeat (off) @(negedge clk);
      clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      repeat (15) @(negedge clk);
      idle_gap();
      check("clear_coincident", vcount - base, 0);
      check("clear_coincident_word", word_out, 16'hEF56);
    end

    // Asynchronous reset mid-frame
    show(0, 7'h07, 20); show(1, 7'h7F, 20);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {word_out, word_valid, digit_err, err_any}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    base = vcount;
    show(3, 7'h6F, 20); show(2, 7'h07, 20); show(1, 7'h06, 20); show(0, 7'h3F, 20);
    idle_gap();
    check("post_rst_count", vcount - base, 1);
    check("post_rst_word", word_out, 16'h9710);

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 150; i++) begin
      int mode;
      logic [6:0] pat;
      mode = $urandom_range(0, 9);
      pat  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
      if (mode == 0)      drive('1, pat, $urandom_range(4, 20));
      else if (mode == 1) drive(N'($urandom), pat, $urandom_range(4, 20));
      else                show($urandom_range(0, N - 1), pat, $urandom_range(4, 20));
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
      end
    end
    idle_gap();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
